// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver: 8 data bits, optional odd/even parity, one stop bit.
// Reports parity, framing and false-start errors alongside each received byte.
module uart_rx_framer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int OVS    = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] DATA_RX,
    output logic       rx_done_flag,
    output logic       rx_busy,
    output logic [2:0] error_flag
);

    localparam int DIV_9600   = (CLK_HZ / (OVS * 9600))   > 1 ? CLK_HZ / (OVS * 9600)   : 1;
    localparam int DIV_19200  = (CLK_HZ / (OVS * 19200))  > 1 ? CLK_HZ / (OVS * 19200)  : 1;
    localparam int DIV_38400  = (CLK_HZ / (OVS * 38400))  > 1 ? CLK_HZ / (OVS * 38400)  : 1;
    localparam int DIV_115200 = (CLK_HZ / (OVS * 115200)) > 1 ? CLK_HZ / (OVS * 115200) : 1;
    localparam int DIV_W      = $clog2(DIV_9600 + 1);
    localparam int TW         = $clog2(OVS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_meta_reg;
    logic             rxs_reg;
    logic [1:0]       sync_fill_reg;
    logic [2:0]       state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_sel;
    logic [TW-1:0]    tick_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [1:0]       baud_lat_reg;
    logic             par_en_reg;
    logic             par_odd_reg;
    logic             parity_err_reg;
    logic             frame_err_reg;
    logic             brk_reg;
    logic             done_pend_reg;
    logic             tick;
    logic             bit_end;

    always_comb begin
        div_sel = DIV_W'(DIV_115200);
        case (baud_lat_reg)
            2'b00:   div_sel = DIV_W'(DIV_9600);
            2'b01:   div_sel = DIV_W'(DIV_19200);
            2'b10:   div_sel = DIV_W'(DIV_38400);
            default: div_sel = DIV_W'(DIV_115200);
        endcase
    end

    assign tick    = (state_reg != IDLE) && (div_cnt_reg == div_sel - DIV_W'(1));
    // The start bit is sampled at its midpoint; every later bit one full bit period on.
    assign bit_end = tick && (tick_cnt_reg == ((state_reg == START) ? HALF_LAST : BIT_LAST));
    assign rx_busy = (state_reg != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta_reg    <= 1'b1;
            rxs_reg        <= 1'b1;
            sync_fill_reg  <= 2'b00;
            state_reg      <= IDLE;
            div_cnt_reg    <= '0;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            baud_lat_reg   <= 2'b00;
            par_en_reg     <= 1'b0;
            par_odd_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            brk_reg        <= 1'b1;
            done_pend_reg  <= 1'b0;
            DATA_RX        <= 8'h00;
            rx_done_flag   <= 1'b0;
            error_flag     <= 3'b000;
        end else begin
            rx_meta_reg   <= rx;
            rxs_reg       <= rx_meta_reg;
            sync_fill_reg <= {sync_fill_reg[0], 1'b1};
            rx_done_flag  <= 1'b0;
            done_pend_reg <= 1'b0;

            if (done_pend_reg) begin
                DATA_RX      <= shift_reg;
                error_flag   <= {1'b0, frame_err_reg, parity_err_reg};
                rx_done_flag <= 1'b1;
            end

            if (state_reg == IDLE || tick) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end

            if (state_reg == IDLE || bit_end) begin
                tick_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end

            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    // A low line only counts as a start bit once it has been seen
                    // high after a break or a reset (reset values of the synchronizer excluded).
                    if (rxs_reg && sync_fill_reg[1]) begin
                        brk_reg <= 1'b0;
                    end
                    if (!rxs_reg && !brk_reg) begin
                        state_reg      <= START;
                        baud_lat_reg   <= baud_rate;
                        par_en_reg     <= (parity_type == 2'b01) || (parity_type == 2'b10);
                        par_odd_reg    <= (parity_type == 2'b01);
                        parity_err_reg <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (rxs_reg) begin
                            state_reg  <= IDLE;
                            error_flag <= 3'b100;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg   <= {rxs_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= par_en_reg ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        parity_err_reg <= (^shift_reg) ^ rxs_reg ^ par_odd_reg;
                        state_reg      <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        frame_err_reg <= ~rxs_reg;
                        brk_reg       <= ~rxs_reg;
                        done_pend_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer at 1.8432 MHz / 115200 baud (16 clocks per bit).
// Expected bytes and error codes are queued when a frame is sent and checked on each done pulse.
module tb_uart_rx_framer;

    logic       clk = 1'b0;
    logic       PRESETn = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate = 2'b11;
    logic [7:0] DATA_RX;
    logic       rx_done_flag;
    logic       rx_busy;
    logic [2:0] error_flag;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;

    uart_rx_framer #(.CLK_HZ(1_843_200), .OVS(16)) dut (
        .PCLK(clk),
        .PRESETn(PRESETn),
        .rx(rx),
        .parity_type(parity_type),
        .baud_rate(baud_rate),
        .DATA_RX(DATA_RX),
        .rx_done_flag(rx_done_flag),
        .rx_busy(rx_busy),
        .error_flag(error_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_flag === 1'b1) begin
            exp_t e;
            done_count++;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got data %h err %b, required no done pulse", DATA_RX, error_flag);
            end else begin
                e = q.pop_front();
                if ({DATA_RX, error_flag} !== {e.data, e.err}) begin
                    miscompares++;
                    $display("FAIL frame_result: got data %h err %b, required data %h err %b",
                             DATA_RX, error_flag, e.data, e.err);
                end else begin
                    $display("frame: data %h err %b", DATA_RX, error_flag);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    // Caller must be aligned to a negedge; the start bit is driven immediately.
    task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par_bit, input bit stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx = par_bit;
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({DATA_RX, rx_done_flag, rx_busy, error_flag} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h %b %b %b, required all zero", DATA_RX, rx_done_flag, rx_busy, error_flag);
        end
        PRESETn = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({DATA_RX, rx_done_flag, rx_busy, error_flag} !== 13'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h %b %b %b, required all zero", DATA_RX, rx_done_flag, rx_busy, error_flag);
        end
    endtask

    task automatic test_no_parity;
        int cycles;
        parity_type = 2'b00;
        q.push_back('{data: 8'hA5, err: 3'b000});
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                cycles = 0;
                while (rx_done_flag !== 1'b1 && cycles < 400) begin
                    @(negedge clk);
                    cycles++;
                end
            end
        join
        // rx changes half a clock before the capturing edge, then 2 sync + 152 ticks + 1.
        vectors++;
        if (cycles != 1 + 2 + 8 + 16 * 9 + 1) begin
            miscompares++;
            $display("FAIL latency_no_parity: got %0d cycles, required %0d", cycles, 1 + 2 + 8 + 16 * 9 + 1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_parity;
        logic [7:0] td[5]  = '{8'h03, 8'h03, 8'hB7, 8'hB7, 8'h5A};
        logic [1:0] tp[5]  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
        logic       tb_[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] te[5]  = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
        for (int k = 0; k < 5; k++) begin
            int cycles;
            int lat;
            bit pen;
            pen = (tp[k] == 2'b01) || (tp[k] == 2'b10);
            lat = 1 + 2 + 8 + 16 * (9 + (pen ? 1 : 0)) + 1;
            parity_type = tp[k];
            q.push_back('{data: td[k], err: te[k]});
            fork
                send_frame(td[k], pen, tb_[k], 1'b1);
                begin
                    cycles = 0;
                    while (rx_done_flag !== 1'b1 && cycles < 400) begin
                        @(negedge clk);
                        cycles++;
                    end
                end
            join
            vectors++;
            if (cycles != lat) begin
                miscompares++;
                $display("FAIL latency_parity_%0d: got %0d cycles, required %0d", k, cycles, lat);
            end
            repeat (4) @(negedge clk);
        end
        parity_type = 2'b00;
    endtask

    task automatic test_framing_break;
        int busy_seen;
        q.push_back('{data: 8'h55, err: 3'b010});
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (rx_busy === 1'b1) busy_seen++;
        end
        vectors++;
        if (busy_seen != 0) begin
            miscompares++;
            $display("FAIL break_suppression: got busy for %0d cycles with line low, required 0", busy_seen);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        q.push_back('{data: 8'h81, err: 3'b000});
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL break_recovery: got %0d frames outstanding, required 0", q.size());
        end
    endtask

    task automatic test_false_start;
        int done_before;
        int busy_seen;
        done_before = done_count;
        busy_seen = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rx_busy === 1'b1) busy_seen++;
        end
        vectors++;
        if (busy_seen == 0) begin
            miscompares++;
            $display("FAIL false_start_busy: got busy for 0 cycles, required a busy period");
        end
        vectors++;
        if ({error_flag, rx_busy} !== {3'b100, 1'b0}) begin
            miscompares++;
            $display("FAIL false_start_flags: got err %b busy %b, required err 100 busy 0", error_flag, rx_busy);
        end
        vectors++;
        if (DATA_RX !== 8'h81 || done_count != done_before) begin
            miscompares++;
            $display("FAIL false_start_hold: got data %h dones %0d, required data 81 dones %0d",
                     DATA_RX, done_count - done_before, 0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int done_before;
        done_before = done_count;
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (60) @(negedge clk);
                vectors++;
                if (rx_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL mid_frame_busy: got %b, required 1", rx_busy);
                end
                #2;
                PRESETn = 1'b0;
                #1;
                vectors++;
                if ({DATA_RX, rx_done_flag, rx_busy, error_flag} !== 13'd0) begin
                    miscompares++;
                    $display("FAIL async_reset: got %h %b %b %b, required all zero",
                             DATA_RX, rx_done_flag, rx_busy, error_flag);
                end
                repeat (3) @(negedge clk);
                PRESETn = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        vectors++;
        if (done_count != done_before) begin
            miscompares++;
            $display("FAIL reset_abort: got %0d done pulses, required 0", done_count - done_before);
        end
        q.push_back('{data: 8'h3C, err: 3'b000});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int done_before;
        done_before = done_count;
        q.push_back('{data: 8'h12, err: 3'b000});
        q.push_back('{data: 8'h34, err: 3'b000});
        fork
            begin
                send_frame(8'h12, 1'b0, 1'b0, 1'b1);
                send_frame(8'h34, 1'b0, 1'b0, 1'b1);
            end
            begin
                repeat (40) @(negedge clk);
                baud_rate = 2'b00;
                parity_type = 2'b10;
                repeat (100) @(negedge clk);
                baud_rate = 2'b11;
                parity_type = 2'b00;
            end
        join
        repeat (6) @(negedge clk);
        vectors++;
        if (done_count - done_before != 2) begin
            miscompares++;
            $display("FAIL back_to_back_count: got %0d done pulses, required 2", done_count - done_before);
        end
    endtask

    initial begin
        test_reset;
        repeat (4) @(negedge clk);
        test_no_parity;
        test_parity;
        test_framing_break;
        test_false_start;
        test_reset_mid_frame;
        test_back_to_back;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter OVS, default 16, oversampling ticks per bit.
REQ-003 SHALL have port PCLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  serial line; idle high; asynchronous to PCLK.
REQ-006 SHALL have port parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none.
REQ-007 SHALL have port baud_rate  input  2  00 = 9600, 01 = 19200, 10 = 38400, 11 = 115200.
REQ-008 SHALL have port DATA_RX  output  8  last received byte.
REQ-009 SHALL have port rx_done_flag  output  1  one-cycle pulse on frame completion.
REQ-010 SHALL have port rx_busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port error_flag  output  3  [0] parity error, [1] framing error, [2] false start.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rxs.
REQ-013 The tick generator SHALL assert a one-cycle tick every DIV = max(1, CLK_HZ/(OVS*baud)) cycles, with integer truncation.
REQ-014 The tick counter SHALL be held at 0 in IDLE and restart at 0 on leaving IDLE, so sampling phase is set by the start edge.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START when rxs = 0; parity_type and baud_rate SHALL be latched that cycle; later input changes are ignored until the next IDLE.
REQ-017 START: after OVS/2 ticks, sample rxs. If 0, go to DATA. If 1, go to IDLE, pulse no done, and set error_flag = 3'b100.
REQ-018 DATA: sample rxs every OVS ticks; 8 samples taken LSB first into the shift register; then go to PARITY if parity is enabled, else STOP.
REQ-019 PARITY: sample after OVS ticks. Error if the XOR of the 8 data bits and the parity bit is 0 for odd, or 1 for even.
REQ-020 STOP: sample after OVS ticks. Sample of 0 = framing error. Then return to IDLE.
REQ-021 In the cycle after the stop sample: DATA_RX loads the shift register, error_flag = {1'b0, frame_err, parity_err}, and rx_done_flag = 1 for exactly one cycle.
REQ-022 DATA_RX and error_flag SHALL hold their values until the next completion or false start.
REQ-023 A framing error SHALL still deliver data and the done pulse.
REQ-024 rx_busy = 1 in every state other than IDLE.
REQ-025 A stop bit that reads 0 SHALL NOT start a new frame until rxs has been seen high in IDLE (break suppression).
REQ-026 Back-to-back frames: a start bit immediately after the stop sample SHALL be detected with no lost frame.
REQ-027 Latency: done pulse = 2 sync cycles + (OVS/2 + OVS*(9+P)) ticks + 1 cycle after the rx falling edge, where P = 1 if parity is enabled, else 0.

Reset
REQ-028 On PRESETn = 0, immediately and asynchronously: FSM = IDLE; counters = 0; DATA_RX = 8'h00; rx_done_flag = 0; rx_busy = 0; error_flag = 3'b000.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block waits for rxs high, then a new start bit.

Verification (CLK_HZ = 1_843_200, baud_rate = 11 so DIV = 1 and bit = 16 clocks)
REQ-030 No parity, send 0xA5 with a good stop bit -> DATA_RX = 8'hA5, error_flag = 000, one done pulse at the REQ-027 cycle.
REQ-031 Even parity, send 0x03 with parity bit 1 -> DATA_RX = 8'h03, error_flag = 001, done pulse.
REQ-032 No parity, send 0x55 with stop bit 0 -> DATA_RX = 8'h55, error_flag = 010; no new frame until the line returns high.
REQ-033 Drive rx low for 4 clocks then high -> no done pulse, error_flag = 100, rx_busy back to 0.
REQ-034 Assert PRESETn low mid-DATA of 0xFF -> all outputs 0 at once; a following 0x3C frame is received correctly.
REQ-035 Send back-to-back frames 0x12 then 0x34 and change baud_rate during the first -> two done pulses, values 12 then 34, first frame at the original baud.
